// File: rtl/aes_mix_columns.sv
// AES MixColumns / InvMixColumns over all four columns of a 128-bit column-major state.
// The result is registered with a one-cycle latency; valid travels alongside the data.
module aes_mix_columns (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         inverse,
  input  logic [127:0] in_state,
  output logic         out_valid,
  output logic [127:0] out_state
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // The inverse coefficients decompose into x8/x4/x2/x1 terms of one xtime chain.
  function automatic logic [7:0] mul9(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv) begin
      b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end else begin
      b0 = mul2(a0) ^ mul3(a1) ^ a2 ^ a3;
      b1 = a0 ^ mul2(a1) ^ mul3(a2) ^ a3;
      b2 = a0 ^ a1 ^ mul2(a2) ^ mul3(a3);
      b3 = mul3(a0) ^ a1 ^ a2 ^ mul2(a3);
    end
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    end
    return r;
  endfunction

  logic [127:0] mixed_p0;
  logic [127:0] state_p1;
  logic         vld_p1;

  always_comb begin
    mixed_p0 = mix_state(in_state, inverse);
  end

  // p0 -> p1: the data register clears on reset too, so out_state reads zero while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      state_p1 <= '0;
    end else begin
      vld_p1   <= in_valid;
      state_p1 <= mixed_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_state = state_p1;

endmodule

// File: tb/tb_aes_mix_columns.sv
// Randomized scoreboard bench for aes_mix_columns against a generic GF(2^8) matrix model.
module tb_aes_mix_columns;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         inverse;
  logic [127:0] in_state;
  logic         out_valid;
  logic [127:0] out_state;

  aes_mix_columns dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .inverse  (inverse),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_state(out_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [127:0] st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic rst_s = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // Shift-and-add GF(2^8) multiply modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Row r of the matrix is the base row rotated right by r positions.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(base[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic drive(input bit v, input bit inv, input logic [127:0] s,
                       input logic [127:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    inverse  = inv;
    in_state = s;
    if (v) begin
      e.cyc = cyc + 1;
      e.st  = expv;
      q.push_back(e);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every cycle after the first edge, compare against reset expectations or the scoreboard.
  always @(negedge clk) begin
    bit exp_v;
    if (cyc > 0) begin
      n_checks++;
      if ($isunknown({out_valid, out_state})) begin
        n_fail++;
        $display("FAIL xcheck cyc=%0d out_valid=%b out_state=%h", cyc, out_valid, out_state);
      end
      if (rst_s) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_state !== 128'h0) begin
          n_fail++;
          $display("FAIL reset_out cyc=%0d got valid=%b state=%h want valid=0 state=0",
                   cyc, out_valid, out_state);
        end
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_output cyc=%0d expected at cyc=%0d state=%h", cyc, q[0].cyc,
                   q[0].st);
          void'(q.pop_front());
        end
        exp_v = (q.size() > 0 && q[0].cyc == cyc);
        n_checks++;
        if (out_valid !== exp_v) begin
          n_fail++;
          $display("FAIL out_valid cyc=%0d got %b want %b", cyc, out_valid, exp_v);
        end
        if (exp_v) begin
          if (out_valid === 1'b1) begin
            n_checks++;
            if (out_state !== q[0].st) begin
              n_fail++;
              $display("FAIL out_state cyc=%0d got %h want %h", cyc, out_state, q[0].st);
            end
          end
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [127:0] s;
    logic [127:0] f;
    rst      = 1'b1;
    in_valid = 1'b1;
    inverse  = 1'b0;
    in_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    drive(0, 0, 128'h0, 128'h0);

    // Known vectors
    drive(1, 0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h046681e5e0cb199a48f8d37a2806264c);
    drive(1, 1, 128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    drive(1, 0, 128'hdb135345f20a225c01010101c6c6c6c6, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    drive(1, 1, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 128'hdb135345f20a225c01010101c6c6c6c6);
    drive(1, 0, 128'h0, 128'h0);
    drive(1, 1, 128'h0, 128'h0);
    drive(0, 0, 128'h0, 128'h0);

    // Back-to-back alternating directions, then a single-cycle gap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        s = rand128();
        drive(1, i[0], s, ref_mix(s, i[0]));
      end
      drive(0, $urandom_range(0, 1), rand128(), 128'h0);
    end

    // Random round trip: forward result fed straight back through the inverse
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      f = ref_mix(s, 0);
      drive(1, 0, s, f);
      drive(1, 1, f, s);
      if ($urandom_range(0, 15) == 0) drive(0, 0, rand128(), 128'h0);
    end

    repeat (3) drive(0, 0, 128'h0, 128'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
